// File: rtl/cast5_ror.sv
// Iterative CAST5 right-rotate engine: one binary stage (16/8/4/2/1) per clock behind valid/ready.
// Optional macro CAST5_ROR_ZERO_BYPASS_EN sends amount-0 words straight to DONE.
module cast5_ror (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_amt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_n;
    logic [31:0] work_r;
    logic [4:0]  amt_r;
    logic [2:0]  stage_r;
    logic [31:0] out_data_r;
    logic        out_valid_r;
    logic [31:0] stage_res_s;

    // Stage s rotates right by 2^(4-s) when amount bit (4-s) is set.
    function automatic logic [31:0] ror_stage(input logic [31:0] w, input logic [2:0] s,
                                              input logic [4:0] a);
        logic [31:0] r;
        case (s)
            3'd0:    r = a[4] ? {w[15:0], w[31:16]} : w;
            3'd1:    r = a[3] ? {w[7:0],  w[31:8]}  : w;
            3'd2:    r = a[2] ? {w[3:0],  w[31:4]}  : w;
            3'd3:    r = a[1] ? {w[1:0],  w[31:2]}  : w;
            3'd4:    r = a[0] ? {w[0],    w[31:1]}  : w;
            default: r = w;
        endcase
        return r;
    endfunction

    assign stage_res_s = ror_stage(work_r, stage_r, amt_r);
    assign in_ready    = (state_r == IDLE) && rst_n;
    assign busy        = (state_r == ROT) || (state_r == DONE);
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;

    // Next-state decode.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
`ifdef CAST5_ROR_ZERO_BYPASS_EN
                    state_n = (in_amt == 5'd0) ? DONE : ROT;
`else
                    state_n = ROT;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            ROT: begin
                if (stage_r == 3'd4) begin
                    state_n = DONE;
                end else begin
                    state_n = ROT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register and datapath; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            work_r      <= 32'h0;
            amt_r       <= 5'd0;
            stage_r     <= 3'd0;
            out_data_r  <= 32'h0;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= state_n;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        work_r  <= in_data;
                        amt_r   <= in_amt;
                        stage_r <= 3'd0;
`ifdef CAST5_ROR_ZERO_BYPASS_EN
                        if (in_amt == 5'd0) begin
                            out_data_r  <= in_data;
                            out_valid_r <= 1'b1;
                        end
`endif
                    end
                end
                ROT: begin
                    work_r <= stage_res_s;
                    if (stage_r == 3'd4) begin
                        out_data_r  <= stage_res_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        stage_r <= stage_r + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cast5_ror.sv
// Self-checking bench for cast5_ror: directed vectors plus a queue-based ROR model checked every cycle.
`timescale 1ns/1ps
module tb_cast5_ror;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    cast5_ror dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [31:0] m_rol(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every cycle a result is presented it must match the oldest accepted word's ROR.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out: got %h expected no result", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL model_out: got %h expected %h", out_data, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(m_ror(in_data, int'(in_amt)));
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] a, input bit rnd,
                        output logic [31:0] got, output int lat);
        int  n;
        bit  busy_ok;
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_amt   = 5'($urandom);
        busy_ok  = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        chk("busy_during_op", 32'(busy_ok), 32'd1);
        got = out_data;
        if (rnd) begin
            out_ready = 1'($urandom_range(0, 1));
            n = 0;
            while (!out_ready && n < 4) begin
                @(posedge clk); #1; n++;
                chk("hold_data", out_data, got);
                out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
        end
        chk("no_turnaround", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] x;
        int          lat;
        int          n;
        bit          quiet;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_amt = 5'd0; out_ready = 1'b1;

        chk("pin_ror16", m_ror(32'hDEADBEEF, 16), 32'hBEEFDEAD);
        chk("pin_ror4", m_ror(32'h23456781, 4), 32'h12345678);
        chk("pin_rol1", m_rol(32'h80000001, 1), 32'h00000003);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        send(32'hDEADBEEF, 5'd16, 1'b0, got, lat);
        chk("ror16_data", got, 32'hBEEFDEAD);
        chk("ror16_lat", 32'(lat), 32'd5);
        send(32'h00000001, 5'd1, 1'b0, got, lat);
        chk("ror1_data", got, 32'h80000000);
        send(32'h80000000, 5'd31, 1'b0, got, lat);
        chk("ror31_data", got, 32'h00000001);
        chk("ror31_lat", 32'(lat), 32'd5);
        send(32'h23456781, 5'd4, 1'b0, got, lat);
        chk("ror4_data", got, 32'h12345678);
        send(32'hA5A5F00F, 5'd0, 1'b0, got, lat);
        chk("ror0_data", got, 32'hA5A5F00F);
`ifdef CAST5_ROR_ZERO_BYPASS_EN
        chk("ror0_lat", 32'(lat), 32'd0);
`else
        chk("ror0_lat", 32'(lat), 32'd5);
`endif

        // Backpressure: sink stalls for three cycles after the result appears.
        in_valid = 1'b1; in_data = 32'hCAFEF00D; in_amt = 5'd12; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 32'hFFFFFFFF; in_amt = 5'd3;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, 32'h00DCAFEF);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_hs_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hs_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp_after_in_ready", 32'(in_ready), 32'd1);
        chk("bp_after_valid", 32'(out_valid), 32'd0);

        // Reset lands on the second stage edge of an accepted word.
        in_valid = 1'b1; in_data = 32'h12345678; in_amt = 5'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_data", out_data, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid || busy) quiet = 1'b0;
        end
        chk("abort_no_result", 32'(quiet), 32'd1);
        send(32'h12345678, 5'd7, 1'b0, got, lat);
        chk("post_abort_data", got, 32'hF02468AC);

        // Regression over all amounts, alternating plain ROR and ROL round trips.
        for (int i = 0; i < 1500; i++) begin
            x = $urandom;
            if (i % 2 == 0) begin
                send(x, 5'(i % 32), 1'b1, got, lat);
                chk("rand_ror", got, m_ror(x, i % 32));
            end else begin
                send(m_rol(x, i % 32), 5'(i % 32), 1'b1, got, lat);
                chk("rand_roundtrip", got, x);
            end
        end
        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
